// File: rtl/seq_div_16_8.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock, valid/ready handshakes on both sides.
module seq_div_16_8 #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]       divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       quotient,
    output logic [WIDTH-1:0]       remainder,
    output logic                   div_by_zero,
    output logic                   overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] low_bits;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    count;
    logic             dbz;
    logic             ovf;

    logic             accept;
    logic             hi_ge;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    assign in_ready  = (state == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign hi_ge     = dividend[2*WIDTH-1:WIDTH] >= divisor;

    // The trial value needs WIDTH+1 bits; after a successful subtract the
    // result is below the divisor, so the low WIDTH bits carry it exactly.
    assign shifted   = {part_rem, low_bits[WIDTH-1]};
    assign fits      = shifted >= {1'b0, dvs};
    assign diff      = shifted[WIDTH-1:0] - dvs;

    assign out_valid   = (state == S_DONE);
    assign quotient    = quo;
    assign remainder   = part_rem;
    assign div_by_zero = dbz;
    assign overflow    = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            part_rem <= '0;
            low_bits <= '0;
            quo      <= '0;
            dvs      <= '0;
            count    <= '0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        dvs <= divisor;
                        if (divisor == '0) begin
                            dbz      <= 1'b1;
                            ovf      <= 1'b0;
                            quo      <= '1;
                            part_rem <= dividend[WIDTH-1:0];
                            low_bits <= '0;
                            count    <= '0;
                            state    <= S_DONE;
                        end else if (hi_ge) begin
                            // Quotient would need more than WIDTH bits.
                            dbz      <= 1'b0;
                            ovf      <= 1'b1;
                            quo      <= '1;
                            part_rem <= '0;
                            low_bits <= '0;
                            count    <= '0;
                            state    <= S_DONE;
                        end else begin
                            dbz      <= 1'b0;
                            ovf      <= 1'b0;
                            quo      <= '0;
                            part_rem <= dividend[2*WIDTH-1:WIDTH];
                            low_bits <= dividend[WIDTH-1:0];
                            count    <= CW'(WIDTH);
                            state    <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    part_rem <= fits ? diff : shifted[WIDTH-1:0];
                    low_bits <= {low_bits[WIDTH-2:0], 1'b0};
                    quo      <= {quo[WIDTH-2:0], fits};
                    count    <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
